// File: rtl/instruction_fetch_unit_if.sv
// Fetch-side bundle: redirect/stall controls and instruction data in, PC and IF/ID out.
interface instruction_fetch_unit_if;
  logic        Stall;
  logic        Branch_Taken;
  logic [31:0] Branch_Target;
  logic        Jump;
  logic [25:0] Jump_Target;
  logic [31:0] Instr;
  logic [31:0] PC;
  logic [31:0] Instr_ID;
  logic [31:0] PCplus1_ID;
  logic        Valid_ID;
  logic        Halted;

  modport master (
    input  Stall, Branch_Taken, Branch_Target, Jump, Jump_Target, Instr,
    output PC, Instr_ID, PCplus1_ID, Valid_ID, Halted
  );
  modport slave (
    output Stall, Branch_Taken, Branch_Target, Jump, Jump_Target, Instr,
    input  PC, Instr_ID, PCplus1_ID, Valid_ID, Halted
  );
endinterface

// File: rtl/instruction_fetch_unit.sv
// Word-addressed fetch stage: PC sequencing, branch/jump redirect, stall, IF/ID register,
// and a halt state when fetch runs off the end of instruction memory.
module instruction_fetch_unit #(
  parameter int RESET_PC  = 0,
  parameter int MEM_WORDS = 32
) (
  input logic                  Clk,
  input logic                  Reset_n,
  instruction_fetch_unit_if.master bus
);
  localparam logic [31:0] PC_RST = 32'(RESET_PC);
  localparam logic [31:0] LAST   = 32'(MEM_WORDS - 1);

  typedef enum logic [1:0] {BOOT, RUN, HALT} state_t;
  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pcp1;
    logic        valid;
  } ifid_t;

  state_t      state;
  ifid_t       ifid;
  logic [31:0] pc;
  logic        halted;
  logic        redirect;
  logic [31:0] tgt;
  logic        tgt_ok;

  // Branch outranks jump; jump keeps the upper PC bits of the instruction in decode.
  always_comb begin
    redirect = bus.Branch_Taken | bus.Jump;
    tgt      = bus.Branch_Taken ? bus.Branch_Target : {ifid.pcp1[31:26], bus.Jump_Target};
    tgt_ok   = (tgt <= LAST);
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state  <= BOOT;
      pc     <= PC_RST;
      ifid   <= '0;
      halted <= 1'b0;
    end else begin
      case (state)
        // One idle edge so memory has a negedge to present RESET_PC's word.
        BOOT: begin
          ifid   <= '0;
          state  <= RUN;
          halted <= 1'b0;
        end
        RUN: begin
          if (redirect) begin
            ifid <= '0;
            if (tgt_ok) pc <= tgt;
            else begin
              state  <= HALT;
              halted <= 1'b1;
            end
          end else if (!bus.Stall) begin
            ifid <= '{instr: bus.Instr, pcp1: pc + 32'd1, valid: 1'b1};
            if (pc == LAST) begin
              state  <= HALT;
              halted <= 1'b1;
            end else begin
              pc <= pc + 32'd1;
            end
          end
        end
        HALT: begin
          if (redirect) begin
            ifid <= '0;
            if (tgt_ok) begin
              pc     <= tgt;
              state  <= RUN;
              halted <= 1'b0;
            end
          end else if (!bus.Stall) begin
            ifid <= '0;
          end
        end
        default: begin
          state  <= BOOT;
          ifid   <= '0;
          halted <= 1'b0;
        end
      endcase
    end
  end

  assign bus.PC         = pc;
  assign bus.Instr_ID   = ifid.instr;
  assign bus.PCplus1_ID = ifid.pcp1;
  assign bus.Valid_ID   = ifid.valid;
  assign bus.Halted     = halted;
endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Directed bench for the fetch unit with a negedge-sampled instruction memory model.
module tb_instruction_fetch_unit;
  logic Clk;
  logic Reset_n;
  int   checks;
  int   errors;
  logic [31:0] mem [32];

  instruction_fetch_unit_if bus ();

  instruction_fetch_unit #(.RESET_PC(0), .MEM_WORDS(32)) dut (
    .Clk    (Clk),
    .Reset_n(Reset_n),
    .bus    (bus.master)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  // Instruction memory reads the PC on the falling edge.
  always @(negedge Clk)
    bus.Instr = (bus.PC < 32'd32) ? mem[bus.PC[4:0]] : 32'h0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge Clk);
    #1;
  endtask

  task automatic ifid(input string tag, input logic [31:0] pc, input logic [31:0] ins,
                      input logic [31:0] p1, input logic v, input logic h);
    chk({tag, ".pc"},    bus.PC, pc);
    chk({tag, ".instr"}, bus.Instr_ID, ins);
    chk({tag, ".pcp1"},  bus.PCplus1_ID, p1);
    chk({tag, ".valid"}, {31'd0, bus.Valid_ID}, {31'd0, v});
    chk({tag, ".halt"},  {31'd0, bus.Halted}, {31'd0, h});
  endtask

  initial begin
    checks = 0;
    errors = 0;
    for (int i = 0; i < 32; i++) mem[i] = 32'h1000_0000 + 32'(i) * 32'h0101;
    bus.Stall = 0; bus.Branch_Taken = 0; bus.Branch_Target = 0;
    bus.Jump = 0; bus.Jump_Target = 0; bus.Instr = 0;
    Reset_n = 0;
    #12;
    ifid("rst", 0, 0, 0, 0, 0);

    // Redirect request during BOOT must be ignored.
    bus.Branch_Taken = 1; bus.Branch_Target = 5;
    Reset_n = 1;
    tick;
    ifid("boot", 0, 0, 0, 0, 0);
    bus.Branch_Taken = 0;
    tick; ifid("seqA", 1, mem[0], 1, 1, 0);
    tick; ifid("seqB", 2, mem[1], 2, 1, 0);
    tick; ifid("seqC", 3, mem[2], 3, 1, 0);

    bus.Stall = 1;
    tick; ifid("stall1", 3, mem[2], 3, 1, 0);
    tick; ifid("stall2", 3, mem[2], 3, 1, 0);
    bus.Stall = 0;
    tick; ifid("unstall", 4, mem[3], 4, 1, 0);
    tick; ifid("seq4", 5, mem[4], 5, 1, 0);

    bus.Jump = 1; bus.Jump_Target = 26'd7;
    tick; ifid("jump", 7, 0, 0, 0, 0);
    bus.Jump = 0;
    tick; ifid("jcap", 8, mem[7], 8, 1, 0);

    bus.Branch_Taken = 1; bus.Branch_Target = 10;
    bus.Jump = 1; bus.Jump_Target = 26'd20; bus.Stall = 1;
    tick; ifid("prio", 10, 0, 0, 0, 0);
    bus.Branch_Taken = 0; bus.Jump = 0; bus.Stall = 0;
    tick; ifid("pcap", 11, mem[10], 11, 1, 0);

    bus.Branch_Taken = 1; bus.Branch_Target = 30;
    tick; ifid("b30", 30, 0, 0, 0, 0);
    bus.Branch_Taken = 0;
    tick; ifid("cap30", 31, mem[30], 31, 1, 0);
    tick; ifid("cap31", 31, mem[31], 32, 1, 1);
    bus.Stall = 1;
    tick; ifid("hstall", 31, mem[31], 32, 1, 1);
    bus.Stall = 0;
    tick; ifid("hbub", 31, 0, 0, 0, 1);
    tick; ifid("hbub2", 31, 0, 0, 0, 1);

    bus.Branch_Taken = 1; bus.Branch_Target = 2;
    tick; ifid("hbr", 2, 0, 0, 0, 0);
    bus.Branch_Taken = 0;
    tick; ifid("cap2", 3, mem[2], 3, 1, 0);
    bus.Branch_Taken = 1; bus.Branch_Target = 40;
    tick; ifid("oor", 3, 0, 0, 0, 1);
    bus.Branch_Taken = 0;

    bus.Jump = 1; bus.Jump_Target = 26'd12;
    tick; ifid("hjmp", 12, 0, 0, 0, 0);
    bus.Jump = 0;
    tick; ifid("cap12", 13, mem[12], 13, 1, 0);

    // Asynchronous reset in the middle of a cycle.
    #2;
    Reset_n = 0;
    #1;
    ifid("arst", 0, 0, 0, 0, 0);
    @(negedge Clk);
    Reset_n = 1;
    tick; ifid("reboot", 0, 0, 0, 0, 0);
    tick; ifid("recap", 1, mem[0], 1, 1, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout: got running want finished");
    $fatal(1);
  end
endmodule

// File: doc/instruction_fetch_unit.md
INSTRUCTION_FETCH_UNIT -- requirements
Module: instruction_fetch_unit

Interface
REQ-001 The block SHALL have parameter RESET_PC, default 0: word address loaded into PC at reset.
REQ-002 The block SHALL have parameter MEM_WORDS, default 32: number of instruction-memory words; valid addresses are 0..MEM_WORDS-1.
REQ-003 The block SHALL use one clock, Clk, and an asynchronous active-low reset, Reset_n, and SHALL have these ports:
- Clk  input  1  clock; all state updates on posedge.
- Reset_n  input  1  asynchronous, active-low reset.
- Stall  input  1  hazard stall; hold PC and IF/ID.
- Branch_Taken  input  1  branch redirect request.
- Branch_Target  input  32  branch target, word address.
- Jump  input  1  decode-stage jump request.
- Jump_Target  input  26  jump field, word address.
- Instr  input  32  instruction-memory data; memory samples PC on negedge Clk.
- PC  output  32  current fetch word address, driven to instruction memory.
- Instr_ID  output  32  IF/ID instruction register.
- PCplus1_ID  output  32  IF/ID register holding fetched PC+1.
- Valid_ID  output  1  IF/ID register holds a real instruction.
- Halted  output  1  fetch stopped at end of memory.

Function
REQ-004 PC addressing SHALL be word-indexed: sequential next PC = PC+1, with 32-bit wrap ignored (the HALT rule governs).
REQ-005 The FSM SHALL have three states, BOOT, RUN and HALT; Halted SHALL be 1 only in HALT.
REQ-006 In BOOT, on one posedge: PC holds, IF/ID loads a bubble, and state moves to RUN; this guarantees a negedge memory read of RESET_PC.
REQ-007 A bubble SHALL mean Instr_ID=0, PCplus1_ID=0 and Valid_ID=0.
REQ-008 In RUN, the posedge priority SHALL be Branch_Taken > Jump > Stall > sequential.
REQ-009 On Branch_Taken, PC SHALL load Branch_Target and IF/ID SHALL load a bubble (flush).
REQ-010 On Jump without Branch_Taken, PC SHALL load {PCplus1_ID[31:26], Jump_Target} and IF/ID SHALL load a bubble.
REQ-011 On Stall without a redirect, PC, Instr_ID, PCplus1_ID and Valid_ID SHALL all hold.
REQ-012 On a sequential cycle, IF/ID SHALL capture Instr, PC+1 and Valid_ID=1, and PC SHALL load PC+1; the fetch-to-IF/ID latency is 1 cycle.
REQ-013 On a sequential cycle with PC==MEM_WORDS-1, IF/ID SHALL capture normally, PC SHALL hold, and state SHALL move to HALT.
REQ-014 A redirect target >= MEM_WORDS SHALL load a bubble, hold PC unchanged and move state to HALT.
REQ-015 In HALT, PC SHALL hold and IF/ID SHALL load a bubble each cycle; with Stall asserted, IF/ID SHALL hold instead.
REQ-016 In HALT, an in-range Branch_Taken or Jump SHALL load PC with the target, load a bubble and move state to RUN.
REQ-017 In BOOT, Stall, Branch_Taken and Jump SHALL be ignored.
REQ-018 The block SHALL contain no combinational path from Instr to PC.

Reset
REQ-019 While Reset_n=0, asynchronously: PC=RESET_PC, Instr_ID=0, PCplus1_ID=0, Valid_ID=0, Halted=0, state=BOOT.
REQ-020 Reset asserted mid-operation, including during HALT or Stall, SHALL override everything immediately; the first posedge after release SHALL execute BOOT.

Verification
REQ-021 Boot: release reset with RESET_PC=0 and memory words 0..2 = A,B,C -> cycle 1 gives bubble with PC=0; cycles 2-4 give Instr_ID=A,B,C, PCplus1_ID=1,2,3, Valid_ID=1.
REQ-022 Stall: Stall=1 for 2 cycles while PC=3 -> PC stays 3 and IF/ID is unchanged; the next cycle captures ins[3], PCplus1_ID=4.
REQ-023 Redirect priority: Branch_Taken=1 with target 10, Jump=1 and Stall=1 in the same cycle -> PC=10 and Valid_ID=0; the next cycle gives PCplus1_ID=11.
REQ-024 Jump: PCplus1_ID=5 and Jump_Target=7 -> PC=7 and a bubble; the following capture gives PCplus1_ID=8.
REQ-025 End of memory: MEM_WORDS=32, sequential from PC=30 -> capture at 30 and 31, then Halted=1 with PC=31 and bubbles; Branch_Taken to 2 gives RUN with PC=2; Branch_Target=40 gives HALT with PC held.
REQ-026 Async reset: assert Reset_n=0 mid-cycle while in RUN at PC=12 -> PC=0, Valid_ID=0 and Halted=0 before the next edge.
